// File: rtl/modn_counter.sv
// Programmable modulo-N up/down counter with synchronous load, cascade carry,
// terminal-count decode and a sticky illegal-load flag.
module modn_counter #(
  parameter int unsigned MODULUS = 3,
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] VAL,
  output logic             CR,
  output logic             TC,
  output logic             ERR
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RST_VAL);

  // Reject parameter sets that could never hold the full count range.
  if (MODULUS < 2) begin : g_mod_chk
    $error("modn_counter: MODULUS must be >= 2");
  end
  if ((64'(1) << WIDTH) < 64'(MODULUS)) begin : g_width_chk
    $error("modn_counter: WIDTH too small for MODULUS");
  end
  if (RST_VAL >= MODULUS) begin : g_rst_chk
    $error("modn_counter: RST_VAL must be < MODULUS");
  end

  logic             at_max;
  logic             at_zero;
  logic             din_ok;
  logic [WIDTH-1:0] val_nxt;
  logic             err_nxt;

  assign at_max  = (VAL == MAX_VAL);
  assign at_zero = (VAL == '0);
  assign din_ok  = (32'(DIN) < MODULUS);

  // Next-state: load beats count beats hold; out-of-range values snap to the wrap target.
  always_comb begin
    val_nxt = VAL;
    err_nxt = ERR & ~ERR_CLR;
    if (LD) begin
      if (din_ok) begin
        val_nxt = DIN;
      end else begin
        val_nxt = MAX_VAL;
        err_nxt = 1'b1;
      end
    end else if (EN) begin
      if (UP) begin
        val_nxt = (VAL >= MAX_VAL) ? '0 : VAL + WIDTH'(1);
      end else begin
        val_nxt = (at_zero || VAL > MAX_VAL) ? MAX_VAL : VAL - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      VAL <= RST_V;
      ERR <= 1'b0;
    end else begin
      VAL <= val_nxt;
      ERR <= err_nxt;
    end
  end

  // Carry/borrow is zero-latency so cascaded stages step on the same edge.
  assign CR = EN & ~LD & ((UP & at_max) | (~UP & at_zero));
  assign TC = at_max;

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench: a mod-3 counter plus a two-stage decimal cascade, checked
// against an arithmetic reference model with directed and random stimulus.
module tb_modn_counter;

  logic       clk;
  logic       rst;
  logic       en, up, ld, clr;
  logic [1:0] din;
  logic [1:0] val;
  logic       cr, tc, err;

  logic       cen;
  logic [3:0] lo_val, hi_val;
  logic       lo_cr, hi_cr, lo_tc, hi_tc, lo_err, hi_err;

  modn_counter #(.MODULUS(3), .WIDTH(2), .RST_VAL(0)) dut (
    .CLK(clk), .RST(rst), .EN(en), .UP(up), .LD(ld), .DIN(din),
    .ERR_CLR(clr), .VAL(val), .CR(cr), .TC(tc), .ERR(err)
  );

  modn_counter #(.MODULUS(10), .WIDTH(4), .RST_VAL(0)) u_lo (
    .CLK(clk), .RST(rst), .EN(cen), .UP(up), .LD(1'b0), .DIN(4'd0),
    .ERR_CLR(1'b0), .VAL(lo_val), .CR(lo_cr), .TC(lo_tc), .ERR(lo_err)
  );

  modn_counter #(.MODULUS(10), .WIDTH(4), .RST_VAL(0)) u_hi (
    .CLK(clk), .RST(rst), .EN(lo_cr), .UP(up), .LD(1'b0), .DIN(4'd0),
    .ERR_CLR(1'b0), .VAL(hi_val), .CR(hi_cr), .TC(hi_tc), .ERR(hi_err)
  );

  typedef struct {
    int val;
    bit tc;
    bit cr;
    bit err;
    int cas;
    bit hcr;
  } exp_t;

  exp_t exp_q[$];

  int  total = 0;
  int  passed = 0;

  int  m_val = 0;
  bit  m_err = 0;
  int  c_val = 0;
  bit  known = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end else begin
      passed++;
    end
  endtask

  // One clock of stimulus: drive inputs, queue this cycle's expected outputs, advance the model.
  task automatic step(input bit rst_i, input bit en_i, input bit up_i, input bit ld_i,
                      input int din_i, input bit clr_i, input bit cen_i);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_i; en = en_i; up = up_i; ld = ld_i; din = 2'(din_i); clr = clr_i; cen = cen_i;
    if (known) begin
      e.val = m_val;
      e.tc  = (m_val == 2);
      e.cr  = en_i && !ld_i && (up_i ? (m_val == 2) : (m_val == 0));
      e.err = m_err;
      e.cas = c_val;
      e.hcr = cen_i && (up_i ? (c_val == 99) : (c_val == 0));
      exp_q.push_back(e);
    end
    if (!rst_i) begin
      m_val = 0; m_err = 0; c_val = 0; known = 1;
    end else if (known) begin
      if (ld_i) m_val = (din_i < 3) ? din_i : 2;
      else if (en_i) m_val = up_i ? (m_val + 1) % 3 : (m_val + 2) % 3;
      if (ld_i && din_i >= 3) m_err = 1;
      else if (clr_i) m_err = 0;
      if (cen_i) c_val = up_i ? (c_val + 1) % 100 : (c_val + 99) % 100;
    end
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("val", 32'(val), 32'(e.val));
      check("tc",  32'(tc),  32'(e.tc));
      check("cr",  32'(cr),  32'(e.cr));
      check("err", 32'(err), 32'(e.err));
      check("cascade", 32'(hi_val) * 10 + 32'(lo_val), 32'(e.cas));
      check("hi_cr", 32'(hi_cr), 32'(e.hcr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; ld = 1'b0; din = 2'd0; clr = 1'b0; cen = 1'b0;
    // Reset overrides a simultaneous load.
    step(0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    // Up-count then down-count.
    repeat (6) step(1, 1, 1, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0, 0, 0);
    // Loads, illegal load, set-wins-over-clear, then clear.
    step(1, 1, 1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 3, 0, 0);
    step(1, 0, 1, 1, 3, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    // Mid-run reset with err set and a pending load.
    step(1, 0, 1, 1, 3, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    // Cascade: full decade wrap up, then down through 00 -> 99.
    repeat (105) step(1, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);
    // Randomised mix of every control.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 29) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 3) != 0);
    end
    step(1, 0, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
